// File: rtl/rng_pkg.sv
// Protocol constants and frame helpers for the laser ranging module link,
// shared by the command encoder and the range-reply decoder.
package rng_pkg;

  localparam logic [7:0] RNG_HDR       = 8'hAA;
  localparam int         RNG_FRAME_LEN = 6;
  localparam int         RNG_FRAME_W   = 8 * RNG_FRAME_LEN;
  localparam logic [2:0] RNG_LAST_IDX  = 3'(RNG_FRAME_LEN - 1);

  typedef enum logic [1:0] {
    RNG_IDLE = 2'd0,
    RNG_LOAD = 2'd1,
    RNG_SEND = 2'd2,
    RNG_DONE = 2'd3
  } rng_state_e;

  // Header is excluded from the checksum; the sum wraps at 8 bits.
  function automatic logic [7:0] rng_checksum(input logic [7:0] addr,
                                              input logic [7:0] code_hi,
                                              input logic [7:0] code_lo,
                                              input logic [7:0] param);
    return addr + code_hi + code_lo + param;
  endfunction

  function automatic logic [RNG_FRAME_W-1:0] rng_build_frame(input logic [7:0]  addr,
                                                             input logic [15:0] code,
                                                             input logic [7:0]  param);
    return {RNG_HDR, addr, code, param,
            rng_checksum(addr, code[15:8], code[7:0], param)};
  endfunction

  // Byte 0 sits in the top octet so the frame reads left to right in send order.
  function automatic logic [7:0] rng_frame_byte(input logic [RNG_FRAME_W-1:0] frame,
                                                input logic [2:0]             idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = frame[47:40];
      3'd1:    b = frame[39:32];
      3'd2:    b = frame[31:24];
      3'd3:    b = frame[23:16];
      3'd4:    b = frame[15:8];
      default: b = frame[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for a single character, LSB first, idle-high line.
// A start pulse is only honoured while no character is in flight.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       Clk,
  input  logic       RstN,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       TxD
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd9;

  logic          r_active;
  logic [CW-1:0] r_tick;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_done;
  logic          r_txd;

  // r_shift holds the remaining data bits with the stop bit parked on top,
  // so the line value for the next bit is always r_shift[0].
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_active <= 1'b0;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_done   <= 1'b0;
      r_txd    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (start) begin
          r_active <= 1'b1;
          r_shift  <= {1'b1, data};
          r_tick   <= '0;
          r_bit    <= '0;
          r_txd    <= 1'b0;
        end
      end else if (r_tick != LAST_TICK) begin
        r_tick <= r_tick + 1'b1;
      end else begin
        r_tick <= '0;
        if (r_bit == LAST_BIT) begin
          r_active <= 1'b0;
          r_bit    <= '0;
          r_done   <= 1'b1;
          r_txd    <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_txd   <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end
    end
  end

  assign done = r_done;
  assign TxD  = r_txd;

endmodule

// File: rtl/rng_cmd_encode.sv
// Command-frame encoder for the laser ranging module: latches a request,
// builds the 6-byte frame with checksum and feeds it byte by byte to the UART.
module rng_cmd_encode
  import rng_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 2604,
  parameter logic [7:0] DEV_ADDR     = 8'h01
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        CmdEn,
  input  logic [15:0] CmdCode,
  input  logic [7:0]  CmdParam,
  output logic        Busy,
  output logic        Done,
  output logic        TxD
);

  rng_state_e             r_state;
  logic [2:0]             r_idx;
  logic [RNG_FRAME_W-1:0] r_frame;
  logic [7:0]             r_byte;
  logic                   r_start;
  logic                   r_busy;
  logic                   r_done;

  logic [RNG_FRAME_W-1:0] w_frame;
  logic [2:0]             w_next_idx;
  logic                   w_tx_done;
  logic                   w_txd;

  assign w_frame    = rng_build_frame(DEV_ADDR, CmdCode, CmdParam);
  assign w_next_idx = r_idx + 3'd1;

  // The byte and its start strobe are registered on entry to LOAD, so the
  // serializer sees them during the LOAD cycle and starts on the next edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= RNG_IDLE;
      r_idx   <= '0;
      r_frame <= '0;
      r_byte  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        RNG_IDLE: begin
          if (CmdEn) begin
            r_frame <= w_frame;
            r_idx   <= '0;
            r_byte  <= rng_frame_byte(w_frame, 3'd0);
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RNG_LOAD;
          end
        end
        RNG_LOAD: begin
          r_state <= RNG_SEND;
        end
        RNG_SEND: begin
          if (w_tx_done) begin
            if (r_idx == RNG_LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= RNG_DONE;
            end else begin
              r_idx   <= w_next_idx;
              r_byte  <= rng_frame_byte(r_frame, w_next_idx);
              r_start <= 1'b1;
              r_state <= RNG_LOAD;
            end
          end
        end
        RNG_DONE: begin
          r_busy  <= 1'b0;
          r_state <= RNG_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= RNG_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .Clk   (Clk),
    .RstN  (RstN),
    .start (r_start),
    .data  (r_byte),
    .done  (w_tx_done),
    .TxD   (w_txd)
  );

  assign Busy = r_busy;
  assign Done = r_done;
  assign TxD  = w_txd;

endmodule

// File: tb/tb_rng_cmd_encode.sv
// Directed bench for rng_cmd_encode: logs the line every cycle and decodes
// frames from the log against hand-computed byte sequences.
module tb_rng_cmd_encode;

  localparam int CPB  = 4;
  localparam int LOGN = 4096;

  logic        Clk = 1'b0;
  logic        RstN = 1'b1;
  logic        CmdEn = 1'b0;
  logic [15:0] CmdCode = '0;
  logic [7:0]  CmdParam = '0;
  logic        Busy;
  logic        Done;
  logic        TxD;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic txd_log  [LOGN];
  logic busy_log [LOGN];
  logic done_log [LOGN];

  rng_cmd_encode #(
    .CLKS_PER_BIT (CPB),
    .DEV_ADDR     (8'h01)
  ) dut (
    .Clk      (Clk),
    .RstN     (RstN),
    .CmdEn    (CmdEn),
    .CmdCode  (CmdCode),
    .CmdParam (CmdParam),
    .Busy     (Busy),
    .Done     (Done),
    .TxD      (TxD)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Cycle k is the clock period that ends at rising edge k.
  always @(negedge Clk) begin
    if (cyc + 1 < LOGN) begin
      txd_log[cyc + 1]  = TxD;
      busy_log[cyc + 1] = Busy;
      done_log[cyc + 1] = Done;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = TxD low, 1 = Busy high, 2 = Done high
  function automatic int count(input int which, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i < LOGN) begin
        case (which)
          0:       if (txd_log[i] !== 1'b1) c++;
          1:       if (busy_log[i] === 1'b1) c++;
          default: if (done_log[i] === 1'b1) c++;
        endcase
      end
    end
    return c;
  endfunction

  task automatic wait_until(input int label);
    while (cyc < label) @(posedge Clk);
    #1;
  endtask

  // Returns n, the cycle in which CmdEn is high; inputs are scrambled afterwards.
  task automatic send(input logic [15:0] code, input logic [7:0] param, output int n);
    @(posedge Clk);
    #1;
    CmdCode  = code;
    CmdParam = param;
    CmdEn    = 1'b1;
    n        = cyc + 1;
    @(posedge Clk);
    #1;
    CmdEn    = 1'b0;
    CmdCode  = 16'hDEAD;
    CmdParam = 8'h5A;
  endtask

  // Byte k start bit begins at n+2+42k; each bit is checked at its first and
  // last clock so any width other than 4 cycles breaks one of the two words.
  task automatic check_frame(input int n, input logic [47:0] exp, input string tag);
    int          s;
    logic [7:0]  eb;
    logic [9:0]  ec;
    logic [9:0]  c0;
    logic [9:0]  c3;
    for (int k = 0; k < 6; k++) begin
      s  = n + 2 + k * (10 * CPB + 2);
      eb = exp[8 * (5 - k) +: 8];
      ec = {1'b1, eb, 1'b0};
      for (int j = 0; j < 10; j++) begin
        c0[j] = txd_log[s + CPB * j];
        c3[j] = txd_log[s + CPB * j + CPB - 1];
      end
      chk($sformatf("%s_b%0d_head", tag, k), c0, ec);
      chk($sformatf("%s_b%0d_tail", tag, k), c3, ec);
      chk($sformatf("%s_b%0d_pre_high", tag, k), txd_log[s - 1], 1);
    end
    chk($sformatf("%s_done_at_n253", tag), done_log[n + 253], 1);
    chk($sformatf("%s_done_count", tag), count(2, n + 1, n + 260), 1);
    chk($sformatf("%s_busy_before", tag), busy_log[n], 0);
    chk($sformatf("%s_busy_cycles", tag), count(1, n + 1, n + 253), 253);
    chk($sformatf("%s_busy_fall", tag), busy_log[n + 254], 0);
  endtask

  initial begin
    int n;
    int n2;
    int r;

    // Reset values
    #2 RstN = 1'b0;
    #1;
    chk("rst_txd", TxD, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_clk_txd", TxD, 1);
    chk("rst_clk_busy", Busy, 0);
    RstN = 1'b1;
    r = cyc + 1;
    wait_until(r + 100);
    chk("idle_txd_low", count(0, r, r + 100), 0);
    chk("idle_done", count(2, r, r + 100), 0);
    chk("idle_busy", count(1, r, r + 100), 0);
    $display("[TB] reset/idle checked at cycle %0d", cyc);

    // Basic frame
    send(16'h0020, 8'h01, n);
    wait_until(n + 270);
    check_frame(n, 48'hAA_01_00_20_01_22, "basic");
    $display("[TB] basic frame accepted at cycle %0d", n);

    // Checksum wrap
    send(16'hFFFF, 8'hFF, n);
    wait_until(n + 270);
    check_frame(n, 48'hAA_01_FF_FF_FF_FE, "wrap");
    $display("[TB] checksum-wrap frame accepted at cycle %0d", n);

    // Busy rejection
    send(16'h1234, 8'h56, n);
    wait_until(n + 100);
    CmdCode  = 16'hBEEF;
    CmdParam = 8'h77;
    CmdEn    = 1'b1;
    @(posedge Clk);
    #1;
    CmdEn = 1'b0;
    wait_until(n + 253 + 60);
    check_frame(n, 48'hAA_01_12_34_56_9D, "reject");
    chk("reject_txd_after_done", count(0, n + 254, n + 313), 0);
    chk("reject_no_second_done", count(2, n + 254, n + 313), 0);
    $display("[TB] busy-rejection frame accepted at cycle %0d", n);

    // Back-to-back with CmdEn held for 600 cycles
    @(posedge Clk);
    #1;
    CmdCode  = 16'h0102;
    CmdParam = 8'h03;
    CmdEn    = 1'b1;
    n        = cyc + 1;
    wait_until(n + 599);
    CmdEn = 1'b0;
    wait_until(n + 800);
    n2 = n + 254;
    check_frame(n, 48'hAA_01_01_02_03_07, "b2b1");
    check_frame(n2, 48'hAA_01_01_02_03_07, "b2b2");
    chk("b2b_idle_high_after_done", count(0, n + 254, n + 255), 0);
    chk("b2b_frame2_start", txd_log[n + 256], 0);
    $display("[TB] back-to-back frames accepted at cycles %0d and %0d", n, n2);

    // Reset during B3 (start bit of B3 spans cycles n+128..n+131)
    send(16'h0A0B, 8'h0C, n);
    wait_until(n + 129);
    chk("rstmid_pre_txd", TxD, 0);
    chk("rstmid_pre_busy", Busy, 1);
    RstN = 1'b0;
    #1;
    chk("rstmid_txd", TxD, 1);
    chk("rstmid_busy", Busy, 0);
    chk("rstmid_done", Done, 0);
    repeat (3) @(posedge Clk);
    #1;
    RstN = 1'b1;
    r = cyc + 1;
    repeat (20) @(posedge Clk);
    #1;
    chk("rstmid_no_resume", count(0, r, r + 19), 0);
    chk("rstmid_no_done", count(2, r, r + 19), 0);
    send(16'h0305, 8'h10, n);
    wait_until(n + 270);
    check_frame(n, 48'hAA_01_03_05_10_19, "after_rst");
    $display("[TB] post-reset frame accepted at cycle %0d", n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
